seq_ripple_subtractor: RTL and testbench
========================================

# seq_ripple_subtractor

Bit-serial unsigned subtractor with borrow-in, the inverse-direction companion to the team's ripple-carry adder. It accepts one operand pair per valid/ready handshake and computes one difference bit per clock, LSB first, through a single full-subtractor cell. It presents the N-bit difference and final borrow on an output valid/ready handshake. It sits where area matters more than throughput, for example in a datapath that already time-multiplexes the adder.

## Interface
- N, 8, operand and difference width in bits; legal for N >= 1.

- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands a, b, bin are valid this cycle.
- in_ready  output  1  block can accept operands; equals (state == IDLE).
- a  input  N  minuend, unsigned.
- b  input  N  subtrahend, unsigned.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/borrow hold a completed result.
- out_ready  input  1  consumer accepts the result this cycle.
- diff  output  N  (a - b - bin) mod 2^N.
- borrow  output  1  1 iff a < b + bin (unsigned, full precision).

## Operation
- States are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a, b into shift registers, latch bin into the borrow flop, clear the bit counter, go to RUN.
- RUN:
  - Each cycle, the full subtractor consumes a_sh[0], b_sh[0] and the borrow flop.
  - The difference bit shifts into the MSB of the diff shift register; the borrow flop takes Bout; a_sh and b_sh shift right.
  - The counter increments. After the Nth bit, go to DONE.
- DONE:
  - out_valid = 1. diff and borrow are stable and do not change while out_valid is high.
  - On out_valid & out_ready: go to IDLE.
- Operands are sampled only at the accept edge. Changes on a, b, bin or in_valid outside IDLE are ignored.
- No same-cycle restart: in_ready rises the cycle after the output handshake.
- Full-subtractor equations: Diff = A ^ B ^ Bin; Bout = (~A & B) | (~(A ^ B) & Bin).
- The counter is $clog2(N+1) bits wide and never wraps within a job.

## Timing
- Reset values, asserted asynchronously while rst_n = 0:
  - state = IDLE, so in_ready = 1 after reset.
  - out_valid = 0, diff = 0, borrow = 0; counter and shift registers are 0.
- Latency: accept at edge k gives out_valid high from edge k+N+1. That is 1 load edge, then N RUN edges, with DONE entered at edge k+N+1.
- Throughput: one job per N+3 cycles when out_ready is tied high (load, N RUN, DONE, IDLE).
- Backpressure: with out_ready low, DONE is held indefinitely with outputs frozen. in_ready stays 0.
- Reset mid-operation (RUN or DONE): the job is abandoned, outputs return to reset values immediately, and no partial result is presented.
- in_valid high during RUN or DONE does not cause acceptance and does not queue.
- diff and borrow may toggle during RUN. The consumer samples them only when out_valid is high.

## Structure
- Shared package seq_sub_pkg holds:
  - typedef state_t (IDLE, RUN, DONE), 2-bit encoding.
  - Constant DEFAULT_N = 8.
- Sub-module full_subtractor: ports A, B, Bin, Diff, Bout. It is purely combinational and instantiated once.
- Top level holds the FSM, counter, the a/b/diff shift registers and the borrow flop.

## Test plan
- N=8, a=200, b=55, bin=0, out_ready=1 -> out_valid exactly 9 edges after accept; diff=145, borrow=0; in_ready returns 1 one cycle after the output handshake.
- N=8, a=5, b=10, bin=0 -> diff=251, borrow=1. Also a=0, b=0, bin=1 -> diff=255, borrow=1. Also a=255, b=255, bin=0 -> diff=0, borrow=0.
- Backpressure: a=100, b=1, bin=1, out_ready low for 5 cycles after out_valid rises -> diff=98, borrow=0 held constant throughout, in_ready=0; handshake on cycle 6, then IDLE.
- Busy rejection: while in RUN, drive in_valid=1 with a=1, b=2 -> not accepted; the original job's result is unchanged, and exactly one out_valid pulse-train occurs.
- Reset mid-RUN: assert rst_n=0 at bit 3 of a job -> out_valid=0, diff=0, borrow=0, in_ready=1 after release. A new job a=9, b=4 then yields diff=5, borrow=0.
- Randomised: 1000 jobs each at N=1, N=8 and N=16, with random in_valid/out_ready gaps -> every result matches the model {borrow, diff} = {1'b0, a} - b - bin taken N+1 bits wide, and no job is lost or duplicated.

Source files
------------

// File: rtl/seq_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state type and
// the default operand width.
package seq_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_N = 8;

endpackage

// File: rtl/seq_ripple_subtractor_if.sv
// Operand / result handshake bundle for seq_ripple_subtractor.
// slave is the subtractor side, master is the producer/consumer side.
interface seq_ripple_subtractor_if
    import seq_sub_pkg::*;
#(
    parameter int N = DEFAULT_N
) ();

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         borrow;

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, borrow
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, borrow
    );

endinterface

// File: rtl/seq_ripple_subtractor_fs.sv
// Single-bit full subtractor cell: computes A - B - Bin.
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/seq_ripple_subtractor.sv
// Bit-serial unsigned subtractor. One operand pair per input handshake,
// one difference bit per clock (LSB first), result held until the
// consumer takes it.
module seq_ripple_subtractor
    import seq_sub_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seq_ripple_subtractor_if.slave bus
);

    // Counter must be able to hold N itself; RUN spends one extra cycle
    // with cnt == N to hand over to DONE, so it never wraps.
    localparam int            CW       = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_sh_q, b_sh_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          borrow_q, borrow_d;
    logic          fs_diff;
    logic          fs_bout;

    full_subtractor u_fs (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Bin  (borrow_q),
        .Diff (fs_diff),
        .Bout (fs_bout)
    );

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;

    // Next-state logic: load in IDLE, one subtract step per RUN cycle,
    // hold everything in DONE until the consumer accepts.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    borrow_d = bus.bin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    a_sh_d   = a_sh_q >> 1;
                    b_sh_d   = b_sh_q >> 1;
                    // New bit enters at the MSB; after N steps the LSB
                    // computed first has reached bit 0.
                    diff_d   = (diff_q >> 1) | (N'(fs_diff) << (N - 1));
                    borrow_d = fs_bout;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

endmodule

// File: tb/tb_seq_ripple_subtractor.sv
// Bench for seq_ripple_subtractor: directed N=8 cases, then concurrent
// randomised runs at N=1, 8 and 16 against an arithmetic model.
module tb_seq_ripple_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   rand_go = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- directed instance, N = 8 ----------------
    seq_ripple_subtractor_if #(.N(8)) bus8 ();

    seq_ripple_subtractor #(.N(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    task automatic accept8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
        @(negedge clk);
        bus8.a        = ta;
        bus8.b        = tb_v;
        bus8.bin      = tbin;
        bus8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin,
                           input logic [8:0] expv, input string tag);
        int cyc;
        bus8.out_ready = 1'b1;
        accept8(ta, tb_v, tbin);
        check({tag, " in_ready busy"}, 32'(bus8.in_ready), 32'd0);
        cyc = 0;
        while (!bus8.out_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd9);
        check({tag, " result"}, 32'({bus8.borrow, bus8.diff}), 32'(expv));
        check({tag, " in_ready in DONE"}, 32'(bus8.in_ready), 32'd0);
        $display("job N=8 a=%0d b=%0d bin=%0d -> diff=%0d borrow=%0d",
                 ta, tb_v, tbin, bus8.diff, bus8.borrow);
        @(posedge clk);
        #1;
        check({tag, " out_valid drop"}, 32'(bus8.out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(bus8.in_ready), 32'd1);
    endtask

    // ---------------- randomised instances ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_rand
        localparam int W = (gi == 0) ? 1 : (gi == 1) ? 8 : 16;

        seq_ripple_subtractor_if #(.N(W)) rbus ();

        seq_ripple_subtractor #(.N(W)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (rbus.slave)
        );

        logic [W:0] exp_q[$];
        int         n_done = 0;
        bit         done_r = 1'b0;

        initial begin : drv
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rbin;
            int           t;
            rbus.in_valid = 1'b0;
            rbus.a        = '0;
            rbus.b        = '0;
            rbus.bin      = 1'b0;
            wait (rand_go);
            for (int j = 0; j < 1000; j++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                @(negedge clk);
                ra   = W'($urandom);
                rb   = W'($urandom);
                rbin = 1'($urandom);
                rbus.a        = ra;
                rbus.b        = rb;
                rbus.bin      = rbin;
                rbus.in_valid = 1'b1;
                t = 0;
                while (!rbus.in_ready && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 200) begin
                    check($sformatf("N%0d accept timeout", W), 32'(t), 32'd0);
                    break;
                end
                exp_q.push_back({1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin});
                @(negedge clk);
                // Busy-time garbage on the operand bus must be ignored.
                rbus.in_valid = 1'b0;
                rbus.a        = W'($urandom);
                rbus.b        = W'($urandom);
                rbus.bin      = 1'($urandom);
            end
        end

        initial begin : mon
            logic [W:0] e;
            int         t;
            rbus.out_ready = 1'b0;
            wait (rand_go);
            t = 0;
            while (n_done < 1000 && t < 60000) begin
                @(negedge clk);
                t++;
                rbus.out_ready = ($urandom_range(0, 3) != 0);
                if (rbus.out_valid && rbus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("N%0d unexpected result", W), 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("N%0d job %0d", W, n_done),
                              32'({rbus.borrow, rbus.diff}), 32'(e));
                        $display("job N=%0d #%0d -> diff=%0d borrow=%0d", W, n_done,
                                 rbus.diff, rbus.borrow);
                    end
                    n_done++;
                end
            end
            check($sformatf("N%0d jobs completed", W), 32'(n_done), 32'd1000);
            repeat (40) @(negedge clk);
            check($sformatf("N%0d leftover", W), 32'(exp_q.size()), 32'd0);
            check($sformatf("N%0d idle after", W), 32'(rbus.out_valid), 32'd0);
            done_r = 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        logic [8:0] held;
        int         pulses;
        int         t;
        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.bin       = 1'b0;
        bus8.out_ready = 1'b0;
        rst_n          = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus8.in_ready), 32'd1);
        check("reset out_valid", 32'(bus8.out_valid), 32'd0);
        check("reset diff", 32'(bus8.diff), 32'd0);
        check("reset borrow", 32'(bus8.borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(8'd200, 8'd55, 1'b0, 9'd145, "200-55");
        run_job(8'd5, 8'd10, 1'b0, {1'b1, 8'd251}, "5-10");
        run_job(8'd0, 8'd0, 1'b1, {1'b1, 8'd255}, "0-0-1");
        run_job(8'd255, 8'd255, 1'b0, 9'd0, "255-255");

        // Backpressure: hold DONE for 5 cycles, outputs frozen.
        bus8.out_ready = 1'b0;
        accept8(8'd100, 8'd1, 1'b1);
        t = 0;
        while (!bus8.out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("bp latency", 32'(t), 32'd9);
        held = {bus8.borrow, bus8.diff};
        check("bp result", 32'(held), 32'd98);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp held", 32'({bus8.borrow, bus8.diff}), 32'd98);
            check("bp out_valid", 32'(bus8.out_valid), 32'd1);
            check("bp in_ready", 32'(bus8.in_ready), 32'd0);
        end
        $display("job N=8 a=100 b=1 bin=1 (backpressure) -> diff=%0d borrow=%0d",
                 bus8.diff, bus8.borrow);
        @(negedge clk);
        bus8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_valid", 32'(bus8.out_valid), 32'd0);
        check("bp release in_ready", 32'(bus8.in_ready), 32'd1);

        // Busy rejection: in_valid during RUN is neither accepted nor queued.
        accept8(8'd50, 8'd20, 1'b0);
        bus8.in_valid = 1'b1;
        bus8.a        = 8'd1;
        bus8.b        = 8'd2;
        repeat (4) @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        pulses = 0;
        held   = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (bus8.out_valid) begin
                pulses++;
                held = {bus8.borrow, bus8.diff};
            end
        end
        check("busy pulses", 32'(pulses), 32'd1);
        check("busy result", 32'(held), 32'd30);
        $display("job N=8 a=50 b=20 bin=0 (busy reject) -> diff=%0d borrow=%0d",
                 held[7:0], held[8]);

        // Reset in the middle of RUN.
        accept8(8'd200, 8'd55, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(bus8.out_valid), 32'd0);
        check("midrst diff", 32'(bus8.diff), 32'd0);
        check("midrst borrow", 32'(bus8.borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst in_ready", 32'(bus8.in_ready), 32'd1);
        run_job(8'd9, 8'd4, 1'b0, 9'd5, "9-4 after reset");

        // Randomised phase on all three widths at once.
        rand_go = 1'b1;
        t = 0;
        while (!(g_rand[0].done_r && g_rand[1].done_r && g_rand[2].done_r) && t < 70000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 70000) check("random phase timeout", 32'(t), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
